// File: rtl/core_tlb_lookup_arb.sv
// core_tlb_lookup_arb: shares one registered TLB lookup port between the
// data path (port 0) and instruction fetch (port 1); results return 1 cycle later.
// Ports: clk, rst (async, active-high); req_valid_i/req_vaddr_i/req_ready_o
// per-port request handshake; flush_i kills the issue slot; tlb_wr_i blocks
// lookups around entry writes; lookup_vaddr_o/lookup_resp_i connect to the TLB;
// resp_valid_o/resp_o route the result to the issuing port.

package core_tlb_pkg;
    typedef struct packed {
        logic        found;
        logic [19:0] ppn;
        logic [5:0]  ps;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_s_resp_t;
endpackage

module core_tlb_lookup_arb
    import core_tlb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid_i,
    input  logic [1:0][31:0] req_vaddr_i,
    output logic [1:0]       req_ready_o,
    input  logic             flush_i,
    input  logic             tlb_wr_i,
    output logic [31:0]      lookup_vaddr_o,
    input  tlb_s_resp_t      lookup_resp_i,
    output logic [1:0]       resp_valid_o,
    output tlb_s_resp_t      resp_o
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    // WR_BLOCK means a write was active last cycle: the entry update
    // lands on that edge, so this cycle is the post-write hold.
    typedef enum logic {
        RUN,
        WR_BLOCK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [1:0]    issued_q;
    logic [1:0]    grant;
    logic          blocked;
    logic          promote;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            starve_q <= '0;
            issued_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            issued_q <= grant;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (tlb_wr_i)  state_d = WR_BLOCK;
            WR_BLOCK: if (!tlb_wr_i) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    assign blocked = rst | flush_i | tlb_wr_i | (state_q != RUN);
    assign promote = (starve_q >= LIM);

    always_comb begin
        grant = 2'b00;
        if (!blocked) begin
            if (promote) begin
                if (req_valid_i[1])      grant = 2'b10;
                else if (req_valid_i[0]) grant = 2'b01;
            end else begin
                if (req_valid_i[0])      grant = 2'b01;
                else if (req_valid_i[1]) grant = 2'b10;
            end
        end
    end

    // Counts every cycle port 1 waits, blocked cycles included.
    always_comb begin
        starve_d = starve_q;
        if (flush_i || !req_valid_i[1] || grant[1])
            starve_d = '0;
        else if (starve_q < LIM)
            starve_d = starve_q + CW'(1);
    end

    assign req_ready_o    = grant;
    assign lookup_vaddr_o = grant[1] ? req_vaddr_i[1] : req_vaddr_i[0];
    assign resp_valid_o   = issued_q;
    assign resp_o         = lookup_resp_i;

endmodule

// File: tb/tb_core_tlb_lookup_arb.sv
// tb_core_tlb_lookup_arb: randomized + directed stimulus against a reference
// arbitration model; a scoreboard queue checks the routed lookup responses.

module tb_core_tlb_lookup_arb;
    import core_tlb_pkg::*;

    localparam int SL = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_vaddr;
    logic [1:0]       req_ready;
    logic             flush;
    logic             tlb_wr;
    logic [31:0]      lookup_vaddr;
    tlb_s_resp_t      tlb_resp;
    logic [1:0]       resp_valid;
    tlb_s_resp_t      resp;

    core_tlb_lookup_arb #(.STARVE_LIMIT(SL)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_vaddr_i    (req_vaddr),
        .req_ready_o    (req_ready),
        .flush_i        (flush),
        .tlb_wr_i       (tlb_wr),
        .lookup_vaddr_o (lookup_vaddr),
        .lookup_resp_i  (tlb_resp),
        .resp_valid_o   (resp_valid),
        .resp_o         (resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  port;
        tlb_s_resp_t resp;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   running = 1'b1;

    // reference model state
    int   m_starve = 0;
    bit   m_prev_wr = 1'b0;

    function automatic tlb_s_resp_t tlb_f(input logic [31:0] va);
        tlb_s_resp_t r;
        r.found = va[13] ^ va[2];
        r.ppn   = va[31:12] ^ 20'hA5A5A;
        r.ps    = va[5:0];
        r.plv   = va[7:6];
        r.mat   = va[9:8];
        r.d     = va[10];
        r.v     = va[11];
        return r;
    endfunction

    // Registered TLB lookup instance stand-in.
    always @(posedge clk) tlb_resp <= tlb_f(lookup_vaddr);

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: response side of the scoreboard.
    always @(negedge clk) begin
        if (running) begin
            vectors++;
            if (rst) begin
                if (resp_valid !== 2'b00) begin
                    miscompares++;
                    $display("FAIL rst_resp cyc=%0d got=%b want=00",
                             cyc, resp_valid);
                end
            end else if (q.size() != 0 && q[0].cyc == cyc) begin
                exp_t e;
                e = q.pop_front();
                if (resp_valid !== e.port || resp !== e.resp) begin
                    miscompares++;
                    $display("FAIL resp cyc=%0d got=%b/%h want=%b/%h",
                             cyc, resp_valid, resp, e.port, e.resp);
                end
            end else if (resp_valid !== 2'b00) begin
                miscompares++;
                $display("FAIL spurious_resp cyc=%0d got=%b want=00",
                         cyc, resp_valid);
            end
        end
    end

    task automatic step(input logic [1:0] v, input logic [31:0] a0,
                        input logic [31:0] a1, input logic fl,
                        input logic wr);
        logic [1:0]  eg;
        logic [31:0] ea;
        bit          blk;
        req_valid    = v;
        req_vaddr[0] = a0;
        req_vaddr[1] = a1;
        flush        = fl;
        tlb_wr       = wr;
        @(negedge clk);
        blk = rst || fl || wr || m_prev_wr;
        eg  = 2'b00;
        if (!blk) begin
            if (m_starve >= SL) eg = v[1] ? 2'b10 : (v[0] ? 2'b01 : 2'b00);
            else                eg = v[0] ? 2'b01 : (v[1] ? 2'b10 : 2'b00);
        end
        ea = eg[1] ? a1 : a0;
        vectors++;
        if (req_ready !== eg) begin
            miscompares++;
            $display("FAIL ready cyc=%0d got=%b want=%b", cyc, req_ready, eg);
        end
        vectors++;
        if (lookup_vaddr !== ea) begin
            miscompares++;
            $display("FAIL lookup_vaddr cyc=%0d got=%h want=%h",
                     cyc, lookup_vaddr, ea);
        end
        if (eg != 2'b00) q.push_back('{port: eg, resp: tlb_f(ea), cyc: cyc + 1});
        if (rst) begin
            m_starve  = 0;
            m_prev_wr = 1'b0;
        end else begin
            if (fl || !v[1] || eg[1]) m_starve = 0;
            else if (m_starve < SL)   m_starve = m_starve + 1;
            m_prev_wr = wr;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd32();
        return $urandom;
    endfunction

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        req_vaddr = '0;
        flush = 1'b0;
        tlb_wr = 1'b0;
        @(posedge clk);
        #1;
        step(2'b11, rnd32(), rnd32(), 1'b0, 1'b0);
        step(2'b11, rnd32(), rnd32(), 1'b0, 1'b0);
        rst = 1'b0;

        // port 0 alone
        step(2'b01, 32'h1000_2000, rnd32(), 1'b0, 1'b0);
        step(2'b00, rnd32(), rnd32(), 1'b0, 1'b0);

        // both valid: starvation promotion pattern
        for (int i = 0; i < 20; i++)
            step(2'b11, rnd32(), rnd32(), 1'b0, 1'b0);

        // two-cycle TLB write with both valid
        step(2'b11, rnd32(), rnd32(), 1'b0, 1'b1);
        step(2'b11, rnd32(), rnd32(), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            step(2'b11, rnd32(), rnd32(), 1'b0, 1'b0);

        // accept port 1, then flush in the response cycle
        step(2'b10, rnd32(), rnd32(), 1'b0, 1'b0);
        step(2'b11, rnd32(), rnd32(), 1'b1, 1'b0);
        step(2'b00, rnd32(), rnd32(), 1'b0, 1'b0);

        // asynchronous reset right after an accept
        step(2'b01, rnd32(), rnd32(), 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        q.delete();
        #1;
        vectors++;
        if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL async_rst got=%b/%b want=00/00",
                     resp_valid, req_ready);
        end
        step(2'b11, rnd32(), rnd32(), 1'b0, 1'b0);
        step(2'b11, rnd32(), rnd32(), 1'b0, 1'b0);
        rst = 1'b0;
        step(2'b11, rnd32(), rnd32(), 1'b0, 1'b0);

        // port 1 alone, back-to-back
        for (int i = 0; i < 10; i++)
            step(2'b10, rnd32(), rnd32(), 1'b0, 1'b0);

        // random mix
        for (int i = 0; i < 600; i++) begin
            logic [1:0] v;
            v = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            step(v, rnd32(), rnd32(),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 14) == 0));
        end

        for (int i = 0; i < 3; i++)
            step(2'b00, rnd32(), rnd32(), 1'b0, 1'b0);
        running = 1'b0;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
